gray_to_rgb_stream: RTL

- Output-side counterpart of the grayscale converter: accepts a stream of single-channel gray pixels and re-expands each to a packed RGB pixel (R=G=B=gray) for the display/output path.
- Provides a valid/ready handshake on both sides with a 2-entry skid buffer for full throughput under backpressure.
- Tracks column and row position and flags start-of-frame, end-of-line and end-of-frame on the output pixel.

---
 rtl/gray_to_rgb_stream.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gray_to_rgb_stream.sv
// -----------------------------------------------------------------------------
// gray_to_rgb_stream
//
// Output-side counterpart of the grayscale converter. Accepts a stream of
// single-channel gray pixels and re-expands each one to a packed RGB pixel
// with R = G = B = gray. Both sides use a valid/ready handshake. A two-entry
// buffer (output register plus one skid register) keeps full throughput
// under backpressure while O_GRAY_READY stays a pure register output.
// Column/row counters describe the pixel currently presented on O_PIXEL and
// drive the start-of-frame, end-of-line and end-of-frame flags.
//
// Ports:
//   I_CLOCK          in   system clock, rising edge
//   I_RESET          in   asynchronous, active-high reset
//   I_GRAY           in   gray pixel data (P_GRAY_DEPTH)
//   I_GRAY_VALID     in   I_GRAY holds a valid pixel
//   O_GRAY_READY     out  block can accept a pixel this cycle (registered)
//   O_PIXEL          out  packed RGB {R,G,B}, R in MSBs (P_PIXEL_DEPTH)
//   O_PIXEL_VALID    out  O_PIXEL and flags are valid
//   I_PIXEL_READY    in   downstream accepts O_PIXEL this cycle
//   O_START_OF_FRAME out  current output pixel is column 0, row 0
//   O_END_OF_LINE    out  current output pixel is the last column
//   O_END_OF_FRAME   out  current output pixel is last column of last row
// -----------------------------------------------------------------------------
module gray_to_rgb_stream #(
  parameter int P_PIXEL_DEPTH  = 24,
  parameter int P_GRAY_DEPTH   = 8,
  parameter int P_IMAGE_WIDTH  = 640,
  parameter int P_IMAGE_HEIGHT = 480
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic [P_GRAY_DEPTH-1:0]  I_GRAY,
  input  logic                     I_GRAY_VALID,
  output logic                     O_GRAY_READY,
  output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
  output logic                     O_PIXEL_VALID,
  input  logic                     I_PIXEL_READY,
  output logic                     O_START_OF_FRAME,
  output logic                     O_END_OF_LINE,
  output logic                     O_END_OF_FRAME
);

  localparam int COL_W = (P_IMAGE_WIDTH  > 1) ? $clog2(P_IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (P_IMAGE_HEIGHT > 1) ? $clog2(P_IMAGE_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMAGE_HEIGHT - 1);

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing buffered
    ST_ONE   = 2'd1,  // output register holds a pixel
    ST_FULL  = 2'd2   // output and skid registers both hold pixels
  } state_t;

  state_t                  state_q;
  logic [P_GRAY_DEPTH-1:0] oreg_q;
  logic [P_GRAY_DEPTH-1:0] skid_q;
  logic                    ready_q;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;

  logic valid;
  logic in_xfer;
  logic out_xfer;

  assign valid    = (state_q != ST_EMPTY);
  assign in_xfer  = I_GRAY_VALID && ready_q;
  assign out_xfer = valid && I_PIXEL_READY;

  // Position of the next output pixel. Counters only move when the pixel in
  // the output register is consumed, so they always describe O_PIXEL.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    col_d = col_q;
    row_d = row_q;
    if (out_xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Buffer state machine. Ready is computed from the next state so that it
  // is a clean register output with no combinational path from
  // I_PIXEL_READY. Ready is held low during reset and rises on the first
  // clock after release.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      // NOTE: the data registers are reset too, not just the control state,
      // because O_PIXEL must read zero while reset is asserted.
      state_q <= ST_EMPTY;
      oreg_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values regardless of statement order.
      col_q <= col_d;
      row_q <= row_d;
      unique case (state_q)
        ST_EMPTY: begin
          ready_q <= 1'b1;
          if (in_xfer) begin
            oreg_q  <= I_GRAY;
            state_q <= ST_ONE;
          end
        end

        ST_ONE: begin
          ready_q <= 1'b1;
          if (in_xfer && !out_xfer) begin
            // Downstream stalled: park the new pixel in the skid register.
            skid_q  <= I_GRAY;
            state_q <= ST_FULL;
            ready_q <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            oreg_q  <= I_GRAY;
          end else if (out_xfer) begin
            state_q <= ST_EMPTY;
          end
        end

        ST_FULL: begin
          // Ready is low here, so no input can arrive in this state.
          if (out_xfer) begin
            oreg_q  <= skid_q;
            state_q <= ST_ONE;
            ready_q <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Pure replication: R = G = B = stored gray value.
  assign O_PIXEL       = {oreg_q, oreg_q, oreg_q};
  assign O_PIXEL_VALID = valid;
  assign O_GRAY_READY  = ready_q;

  assign O_START_OF_FRAME = valid && (col_q == '0) && (row_q == '0);
  assign O_END_OF_LINE    = valid && (col_q == COL_LAST);
  assign O_END_OF_FRAME   = O_END_OF_LINE && (row_q == ROW_LAST);

endmodule
